axi_burst_master: RTL and testbench
===================================

// Module: axi_burst_master
// PURPOSE
// AXI4 master burst engine: the initiator end of the AXI slave port that feeds the DDR controller.
// Takes one command at a time: a write burst with a generated data pattern, or a read burst.
// Drives AW/W/B or AR/R, then reports completion status. Used for DDR traffic generation and bring-up.
// PARAMETERS
// C_M_AXI_ID_WIDTH    2    AWID/ARID/BID/RID width
// C_M_AXI_DATA_WIDTH  128  data width, power of 2, >=32; BYTES = DATA_WIDTH/8
// C_M_AXI_ADDR_WIDTH  41   byte address width
// PORTS
// M_AXI_ACLK    in  1   single clock, all logic rising-edge
// M_AXI_ARESET  in  1   synchronous active-high reset
// cmd_valid     in  1   command request
// cmd_ready     out 1   high only in IDLE
// cmd_write     in  1   1=write burst, 0=read burst
// cmd_id        in  ID  AWID/ARID value
// cmd_addr      in  ADDR  start byte address, driven unmodified
// cmd_len       in  8   AxLEN (beats-1)
// cmd_seed      in  32  pattern seed
// done_valid    out 1   one-cycle completion pulse
// done_resp     out 2   BRESP / worst RRESP / 2'b11 = rejected
// done_err      out 1   read-data or RLAST mismatch (see CONFIGURATION)
// M_AXI_AW*     out     AWID, AWADDR, AWLEN, AWVALID; AWSIZE=log2(BYTES), AWBURST=01
//                       AWLOCK=0, AWCACHE=0011, AWPROT/QOS/REGION=0
// M_AXI_AWREADY in  1
// M_AXI_W*      out     WDATA, WSTRB (all ones), WLAST, WVALID; M_AXI_WREADY in
// M_AXI_B*      in      BID, BRESP, BVALID; M_AXI_BREADY out
// M_AXI_AR*     out     mirrors AW group; M_AXI_ARREADY in
// M_AXI_R*      in      RID, RDATA, RRESP, RLAST, RVALID; M_AXI_RREADY out
// BEHAVIOUR
// Reset:
// - all VALID/READY/LAST outputs, cmd_ready, done_* and counters are 0; state IDLE.
// - Reset mid-burst abandons the transaction; no completion is reported.
// FSM: IDLE -> AW -> W -> B -> IDLE, or IDLE -> AR -> R -> IDLE. Any state -> IDLE on done.
// - IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* fields.
//   - 4KB check: if addr[11:0] + (len+1)*BYTES > 4096, reject. Next cycle done_valid=1,
//     done_resp=2'b11, no bus activity.
// - AW/AR: xVALID=1 from the cycle after capture, held with stable payload until xREADY.
// - W: entered the cycle after the AW handshake.
//   - WVALID=1 continuously; beat counter advances on WVALID&WREADY.
//   - WLAST=1 on beat==len.
//   - Beat i data = the 32-bit word (seed+i) replicated across DATA_WIDTH; wraps mod 2^32.
//   - len=0 gives a single beat with WLAST=1.
// - B: BREADY=1. On BVALID, done_valid=1 next cycle, done_resp=BRESP. BID is not checked.
// - R: RREADY=1; beat counter advances on RVALID.
//   - done_resp = maximum RRESP seen.
//   - Exits on RLAST. RLAST at beat!=len sets done_err.
//   - Beats arriving after beat==len without RLAST are accepted and flagged in done_err.
//     Exit still waits for RLAST.
// - done_valid lasts exactly 1 cycle. cmd_ready returns to 1 in the same cycle.
// - Latency: accepted write with always-ready slave = 1 (AW) + len+1 (W) + B wait + 1 cycles.
// CONFIGURATION
// AXI_RDCHECK_EN
// - Defined: each read beat is compared with the write pattern (seed+i replicated).
//   Any mismatch sets done_err; an 8-bit saturating error count is exported on rd_err_cnt (out 8).
// - Undefined: RDATA is ignored and rd_err_cnt is not present.
//   done_err reports RLAST mismatch only.
// TESTING
// 1. Write addr=0x100, len=3, seed=0xA5A50000, slave always ready -> AW 1 cycle;
//    4 W beats 0xA5A50000..03 with WLAST on the 4th; BRESP=00 -> done_resp=00, done_err=0.
// 2. Read of the same region, slave returns the pattern -> with AXI_RDCHECK_EN done_err=0, rd_err_cnt=0.
//    Corrupt beat 2 -> done_err=1, rd_err_cnt=1.
// 3. Addr=0xFC0, len=7, BYTES=16 (end 0x1040) -> rejected: done_resp=11 one cycle after capture,
//    AWVALID never asserted.
// 4. AWREADY low for 5 cycles, WREADY toggling, BRESP=10 -> AW payload stable,
//    exactly len+1 W handshakes, done_resp=10.
// 5. Read len=3 with RLAST on beat 1 -> done_err=1, exits after beat 1.
// 6. Reset asserted during the W phase at beat 2 -> all VALIDs 0 next cycle, no done_valid,
//    next command accepted normally.

Source files
------------

// File: rtl/axi_burst_master_if.sv
// axi_burst_master_if: AXI4 bus bundle (AW/W/B/AR/R) between the burst master and its slave
interface axi_burst_master_if #(
   parameter int ID_W   = 2,
   parameter int DATA_W = 128,
   parameter int ADDR_W = 41
);
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awlock;
   logic [3:0]          awcache;
   logic [2:0]          awprot;
   logic [3:0]          awqos;
   logic [3:0]          awregion;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ID_W-1:0]     arid;
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arlock;
   logic [3:0]          arcache;
   logic [2:0]          arprot;
   logic [3:0]          arqos;
   logic [3:0]          arregion;
   logic                arvalid;
   logic                arready;
   logic [ID_W-1:0]     rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;
   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-command AXI4 burst engine (pattern writes, reads) for DDR traffic/bring-up.
// Optional read-data pattern checking and rd_err_cnt port when AXI_RDCHECK_EN is defined.
module axi_burst_master #(
   parameter int C_M_AXI_ID_WIDTH   = 2,
   parameter int C_M_AXI_DATA_WIDTH = 128,
   parameter int C_M_AXI_ADDR_WIDTH = 41
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESET,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [C_M_AXI_ID_WIDTH-1:0]   cmd_id,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]                    cmd_len,
   input  logic [31:0]                   cmd_seed,
   output logic                          done_valid,
   output logic [1:0]                    done_resp,
   output logic                          done_err,
`ifdef AXI_RDCHECK_EN
   output logic [7:0]                    rd_err_cnt,
`endif
   axi_burst_master_if.master            m_axi
);
   localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
   localparam int WORDS = C_M_AXI_DATA_WIDTH / 32;
   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;
   state_t                        state, state_nx;
   logic [C_M_AXI_ID_WIDTH-1:0]   id_q;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
   logic [7:0]                    len_q;
   logic [31:0]                   seed_q;
   logic [8:0]                    beat;
   logic [1:0]                    resp_acc;
   logic                          err_acc;
   logic                          accept;
   logic                          cross_4k;
   logic                          last_beat;
   logic                          r_beat;
   logic                          r_err;
   logic                          rd_bad;
   logic [31:0]                   word;
   logic [1:0]                    resp_max;
   logic                          unused;
   assign cmd_ready = state == S_IDLE && !M_AXI_ARESET;
   assign accept    = cmd_ready && cmd_valid;
   assign cross_4k  = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(BYTES) > 32'd4096;
   assign last_beat = beat == {1'b0, len_q};
   assign word      = seed_q + 32'(beat);
   assign r_beat    = state == S_R && m_axi.rvalid;
   assign resp_max  = m_axi.rresp > resp_acc ? m_axi.rresp : resp_acc;
`ifdef AXI_RDCHECK_EN
   assign rd_bad = m_axi.rdata != {WORDS{word}};
   assign unused = ^{m_axi.bid, m_axi.rid};
`else
   assign rd_bad = 1'b0;
   assign unused = ^{m_axi.bid, m_axi.rid, m_axi.rdata};
`endif
   // A read beat is bad on data mismatch, on arriving past the last beat, or on a misplaced RLAST
   assign r_err = rd_bad || beat > {1'b0, len_q} || (m_axi.rlast && !last_beat);
   assign m_axi.awid     = id_q;
   assign m_axi.awaddr   = addr_q;
   assign m_axi.awlen    = len_q;
   assign m_axi.awsize   = 3'($clog2(BYTES));
   assign m_axi.awburst  = 2'b01;
   assign m_axi.awlock   = 1'b0;
   assign m_axi.awcache  = 4'b0011;
   assign m_axi.awprot   = 3'b000;
   assign m_axi.awqos    = 4'h0;
   assign m_axi.awregion = 4'h0;
   assign m_axi.awvalid  = state == S_AW;
   assign m_axi.wdata    = {WORDS{word}};
   assign m_axi.wstrb    = '1;
   assign m_axi.wlast    = state == S_W && last_beat;
   assign m_axi.wvalid   = state == S_W;
   assign m_axi.bready   = state == S_B;
   assign m_axi.arid     = id_q;
   assign m_axi.araddr   = addr_q;
   assign m_axi.arlen    = len_q;
   assign m_axi.arsize   = 3'($clog2(BYTES));
   assign m_axi.arburst  = 2'b01;
   assign m_axi.arlock   = 1'b0;
   assign m_axi.arcache  = 4'b0011;
   assign m_axi.arprot   = 3'b000;
   assign m_axi.arqos    = 4'h0;
   assign m_axi.arregion = 4'h0;
   assign m_axi.arvalid  = state == S_AR;
   assign m_axi.rready   = state == S_R;
   // State register; reset abandons any burst in flight
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) state <= S_IDLE;
      else state <= state_nx;
   end
   // Next-state: rejected commands stay in IDLE and complete from the datapath
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (accept && !cross_4k) state_nx = cmd_write ? S_AW : S_AR;
         S_AW:    if (m_axi.awready) state_nx = S_W;
         S_W:     if (m_axi.wready && last_beat) state_nx = S_B;
         S_B:     if (m_axi.bvalid) state_nx = S_IDLE;
         S_AR:    if (m_axi.arready) state_nx = S_R;
         S_R:     if (m_axi.rvalid && m_axi.rlast) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end
   // Command capture, beat counting, status accumulation and the one-cycle completion pulse
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         seed_q     <= '0;
         beat       <= '0;
         resp_acc   <= '0;
         err_acc    <= 1'b0;
         done_valid <= 1'b0;
         done_resp  <= '0;
         done_err   <= 1'b0;
      end else begin
         done_valid <= 1'b0;
         if (accept) begin
            id_q     <= cmd_id;
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            seed_q   <= cmd_seed;
            beat     <= '0;
            resp_acc <= '0;
            err_acc  <= 1'b0;
            if (cross_4k) begin
               done_valid <= 1'b1;
               done_resp  <= 2'b11;
               done_err   <= 1'b0;
            end
         end
         if (state == S_W && m_axi.wready) beat <= beat + 9'd1;
         if (state == S_B && m_axi.bvalid) begin
            done_valid <= 1'b1;
            done_resp  <= m_axi.bresp;
            done_err   <= 1'b0;
         end
         if (r_beat) begin
            beat     <= beat + 9'(beat != 9'h1ff);
            resp_acc <= resp_max;
            err_acc  <= err_acc | r_err;
            if (m_axi.rlast) begin
               done_valid <= 1'b1;
               done_resp  <= resp_max;
               done_err   <= err_acc | r_err;
            end
         end
      end
   end
`ifdef AXI_RDCHECK_EN
   // Per-command saturating count of read beats whose data differs from the pattern
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) rd_err_cnt <= '0;
      else if (accept) rd_err_cnt <= '0;
      else if (r_beat && rd_bad && rd_err_cnt != 8'hff) rd_err_cnt <= rd_err_cnt + 8'd1;
   end
`endif
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: table-driven bench with a reactive AXI slave model for axi_burst_master
module tb_axi_burst_master;
   localparam int IDW = 2;
   localparam int DW  = 128;
   localparam int AW  = 41;
`ifdef AXI_RDCHECK_EN
   localparam bit RDCHK = 1'b1;
`else
   localparam bit RDCHK = 1'b0;
`endif
   typedef struct {
      logic          wr;
      logic [1:0]    id;
      logic [40:0]   addr;
      logic [7:0]    len;
      logic [31:0]   seed;
      int            aw_stall;
      logic          w_toggle;
      int            b_delay;
      logic [1:0]    bresp;
      int            rlast_at;
      int            corrupt_at;
      logic [1:0]    rresp;
      logic [1:0]    exp_resp;
      logic          exp_err;
      int            exp_cyc;
      int            exp_beats;
      logic [7:0]    exp_cnt;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmd_valid = 1'b0;
   logic cmd_ready;
   logic cmd_write = 1'b0;
   logic [IDW-1:0] cmd_id = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [7:0] cmd_len = '0;
   logic [31:0] cmd_seed = '0;
   logic done_valid;
   logic [1:0] done_resp;
   logic done_err;
`ifdef AXI_RDCHECK_EN
   logic [7:0] rd_err_cnt;
`endif
   int tests = 0;
   int fails = 0;
   vec_t vecs[11];
   always #5 clk = ~clk;
   axi_burst_master_if #(.ID_W(IDW), .DATA_W(DW), .ADDR_W(AW)) bus ();
   axi_burst_master #(.C_M_AXI_ID_WIDTH(IDW), .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
      .M_AXI_ACLK(clk),
      .M_AXI_ARESET(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_id(cmd_id),
      .cmd_addr(cmd_addr),
      .cmd_len(cmd_len),
      .cmd_seed(cmd_seed),
      .done_valid(done_valid),
      .done_resp(done_resp),
      .done_err(done_err),
`ifdef AXI_RDCHECK_EN
      .rd_err_cnt(rd_err_cnt),
`endif
      .m_axi(bus)
   );
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [127:0] pat(input logic [31:0] s, input int i);
      logic [31:0] w;
      w = s + 32'(i);
      return {4{w}};
   endfunction
   task automatic slave_idle();
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bresp   = 2'b00;
      bus.bid     = '0;
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rlast   = 1'b0;
      bus.rresp   = 2'b00;
      bus.rid     = '0;
      bus.rdata   = '0;
   endtask
   task automatic run(input vec_t v, input int n);
      int cyc;
      int aw_hs;
      int ar_hs;
      int beats;
      int stall;
      int bw;
      logic bad_aw;
      logic bad_w;
      logic got;
      logic rdone;
      cyc = 1; aw_hs = 0; ar_hs = 0; beats = 0; stall = 0; bw = 0;
      bad_aw = 1'b0; bad_w = 1'b0; got = 1'b0; rdone = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d cmd_ready_idle", n), cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_id    = v.id;
      cmd_addr  = v.addr;
      cmd_len   = v.len;
      cmd_seed  = v.seed;
      @(negedge clk);
      cmd_valid = 1'b0;
      while (cyc < 2000) begin
         if (done_valid) begin
            got = 1'b1;
            break;
         end
         bus.awready = bus.awvalid && stall >= v.aw_stall;
         if (bus.awvalid) begin
            if (bus.awaddr !== v.addr || bus.awlen !== v.len || bus.awid !== v.id || bus.awsize !== 3'd4 ||
                bus.awburst !== 2'b01 || bus.awcache !== 4'b0011 || bus.awlock !== 1'b0 || bus.awprot !== 3'd0 ||
                bus.awqos !== 4'd0 || bus.awregion !== 4'd0) bad_aw = 1'b1;
            if (bus.awready) aw_hs++;
            else stall++;
         end
         bus.arready = bus.arvalid;
         if (bus.arvalid) begin
            if (bus.araddr !== v.addr || bus.arlen !== v.len || bus.arid !== v.id || bus.arsize !== 3'd4 ||
                bus.arburst !== 2'b01 || bus.arcache !== 4'b0011) bad_aw = 1'b1;
            ar_hs++;
         end
         bus.wready = bus.wvalid && (!v.w_toggle || cyc[0]);
         if (bus.wvalid && bus.wready) begin
            if (bus.wdata !== pat(v.seed, beats) || bus.wlast !== (beats == int'(v.len)) || bus.wstrb !== '1)
               bad_w = 1'b1;
            beats++;
         end
         if (bus.bready) begin
            bw++;
            bus.bvalid = bw > v.b_delay;
            bus.bresp  = v.bresp;
            bus.bid    = v.id;
         end else bus.bvalid = 1'b0;
         if (bus.rready && !rdone) begin
            bus.rvalid = 1'b1;
            bus.rdata  = pat(v.seed, beats) ^ ((beats == v.corrupt_at) ? 128'h1 : 128'h0);
            bus.rlast  = beats == v.rlast_at;
            bus.rresp  = (beats == 1) ? v.rresp : 2'b00;
            bus.rid    = v.id;
            rdone      = bus.rlast;
            beats++;
         end else begin
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      slave_idle();
      chk($sformatf("v%0d done_seen", n), got, 1'b1);
      chk($sformatf("v%0d done_resp", n), done_resp, v.exp_resp);
      chk($sformatf("v%0d done_err", n), done_err, v.exp_err);
      chk($sformatf("v%0d cmd_ready_at_done", n), cmd_ready, 1'b1);
      chk($sformatf("v%0d beats", n), 128'(beats), 128'(v.exp_beats));
      chk($sformatf("v%0d aw_handshakes", n), 128'(aw_hs), 128'(v.wr && v.exp_resp != 2'b11 ? 1 : 0));
      chk($sformatf("v%0d ar_handshakes", n), 128'(ar_hs), 128'(!v.wr && v.exp_resp != 2'b11 ? 1 : 0));
      chk($sformatf("v%0d addr_payload_bad", n), bad_aw, 1'b0);
      chk($sformatf("v%0d wdata_wlast_bad", n), bad_w, 1'b0);
      if (v.exp_cyc > 0) chk($sformatf("v%0d latency", n), 128'(cyc), 128'(v.exp_cyc));
`ifdef AXI_RDCHECK_EN
      chk($sformatf("v%0d rd_err_cnt", n), rd_err_cnt, v.exp_cnt);
`endif
      @(negedge clk);
      chk($sformatf("v%0d done_pulse_1cyc", n), done_valid, 1'b0);
   endtask
   initial begin
      int beats;
      int seen;
      slave_idle();
      //            wr id addr      len seed          aws wt bd br  rl  cor rr  er  ee     cyc  bt   cnt
      vecs[0]  = '{1, 1, 'h100,  3,  'hA5A50000, 0, 0, 0, 0,  0,  -1, 0,  0,  0,     7,   4,   0};
      vecs[1]  = '{0, 2, 'h100,  3,  'hA5A50000, 0, 0, 0, 0,  3,  -1, 0,  0,  0,     6,   4,   0};
      vecs[2]  = '{0, 2, 'h100,  3,  'hA5A50000, 0, 0, 0, 0,  3,  2,  0,  0,  RDCHK, 6,   4,   1};
      vecs[3]  = '{1, 0, 'hFC0,  7,  'h00000001, 0, 0, 0, 0,  0,  -1, 0,  3,  0,     1,   0,   0};
      vecs[4]  = '{1, 3, 'h200,  3,  'h00001234, 5, 1, 2, 2,  0,  -1, 0,  2,  0,     0,   4,   0};
      vecs[5]  = '{0, 1, 'h100,  3,  'hA5A50000, 0, 0, 0, 0,  1,  -1, 0,  0,  1,     4,   2,   0};
      vecs[6]  = '{0, 0, 'h400,  1,  'h00000077, 0, 0, 0, 0,  3,  -1, 2,  2,  1,     6,   4,   0};
      vecs[7]  = '{1, 0, 'hFF0,  0,  'hFFFFFFFF, 0, 0, 0, 1,  0,  -1, 0,  1,  0,     4,   1,   0};
      vecs[8]  = '{1, 0, 'hFF0,  1,  'h00000000, 0, 0, 0, 0,  0,  -1, 0,  3,  0,     1,   0,   0};
      vecs[9]  = '{0, 3, 'h000,  255,'hFFFFFFF0, 0, 0, 0, 0,  255,-1, 1,  1,  0,     258, 256, 0};
      vecs[10] = '{0, 1, 'hF80,  8,  'h00000000, 0, 0, 0, 0,  8,  -1, 0,  3,  0,     1,   0,   0};
      repeat (2) @(negedge clk);
      chk("reset cmd_ready", cmd_ready, 1'b0);
      chk("reset valids", {bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.arvalid, bus.rready}, 6'b0);
      chk("reset done", {done_valid, done_resp, done_err}, 4'b0);
      rst = 1'b0;
      for (int i = 0; i < 11; i++) run(vecs[i], i);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 41'h300;
      cmd_len   = 8'd7;
      cmd_seed  = 32'h0;
      @(negedge clk);
      cmd_valid = 1'b0;
      beats = 0;
      for (int c = 0; c < 20 && beats < 2; c++) begin
         bus.awready = bus.awvalid;
         bus.wready  = bus.wvalid;
         if (bus.wvalid) beats++;
         @(negedge clk);
      end
      chk("midrst reached beat2", 128'(beats), 128'd2);
      chk("midrst in W", bus.wvalid, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      slave_idle();
      chk("midrst valids cleared", {bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.arvalid, bus.rready}, 6'b0);
      chk("midrst no done", done_valid, 1'b0);
      rst = 1'b0;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (done_valid) seen++;
      end
      chk("midrst silent after", 128'(seen), 128'd0);
      run(vecs[0], 100);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
